// File: rtl/dlsc_pcie_s6_pkg.sv
// Shared definitions for the Spartan-6 PCIe request/response path.
// Used by the command splitter and the response merger.
// Contents:
//   - max_size encodings (PCIe Max_Payload/Read_Request_Size field values)
//   - AXI-style response codes
//   - controller state type for the response merger
//   - max_len_dw(): effective split length in DW for a max_size setting
//   - len_mask(): mask used to find the offset within a max_len block
package dlsc_pcie_s6_pkg;

    localparam logic [2:0] MPS_128  = 3'b000;
    localparam logic [2:0] MPS_256  = 3'b001;
    localparam logic [2:0] MPS_512  = 3'b010;
    localparam logic [2:0] MPS_1024 = 3'b011;
    localparam logic [2:0] MPS_2048 = 3'b100;
    localparam logic [2:0] MPS_4096 = 3'b101;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Effective maximum split length in DW (1..1024). The build-time byte
    // limit is capped at 1024 DW; reserved encodings fall back to 128 bytes.
    function automatic logic [10:0] max_len_dw(input logic [2:0] max_size,
                                               input int         max_bytes);
        logic [10:0] cap;
        logic [10:0] enc;
        if ((max_bytes / 4) >= 1024) begin
            cap = 11'd1024;
        end else begin
            cap = 11'(max_bytes / 4);
        end
        case (max_size)
            MPS_128:  enc = 11'd32;
            MPS_256:  enc = 11'd64;
            MPS_512:  enc = 11'd128;
            MPS_1024: enc = 11'd256;
            MPS_2048: enc = 11'd512;
            MPS_4096: enc = 11'd1024;
            default:  enc = 11'd32;
        endcase
        return (enc < cap) ? enc : cap;
    endfunction

    function automatic logic [9:0] len_mask(input logic [10:0] max_len);
        logic [10:0] m;
        m = max_len - 11'd1;
        return m[9:0];
    endfunction

endpackage

// File: rtl/dlsc_pcie_s6_respmerge_cmdq.sv
// Command queue for the response merger: a plain synchronous FIFO.
// Ports:
//   i_push / i_push_data : write side, ignored while o_full
//   i_pop  / o_pop_data  : read side, o_pop_data shows the head entry, pop ignored while o_empty
//   o_full / o_empty     : occupancy flags
// Push and pop in the same cycle both take effect and leave the count unchanged.
module dlsc_pcie_s6_respmerge_cmdq #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dlsc_pcie_s6_respmerge.sv
// Response merger: collapses the per-split responses of one original
// (unsplit) command back into a single response.
// Ports:
//   cmd_*     : original command (addr bits [11:2], length in DW, metadata)
//   max_size  : current max split size encoding, same value the splitter uses
//   in_*      : one response per split produced by the splitter
//   out_*     : one merged response per original command, with its metadata
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no command active; pops the queue head when available
// ST_ACCUM | counting split responses for the active command
module dlsc_pcie_s6_respmerge
    import dlsc_pcie_s6_pkg::*;
#(
    parameter int CMD_DEPTH = 16,
    parameter int MAX_SIZE  = 128,
    parameter int ALIGN     = 0,
    parameter int META      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            cmd_ready,
    input  logic            cmd_valid,
    input  logic [9:0]      cmd_addr,
    input  logic [9:0]      cmd_len,
    input  logic [META-1:0] cmd_meta,
    input  logic [2:0]      max_size,
    output logic            in_ready,
    input  logic            in_valid,
    input  logic [1:0]      in_resp,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [1:0]      out_resp,
    output logic [META-1:0] out_meta
);

    localparam int QW = META + 20;

    state_t          r_state;
    logic [10:0]     r_max_len;
    logic [9:0]      r_rem_len;
    logic [10:0]     r_inc;
    logic [1:0]      r_err;
    logic [META-1:0] r_meta;
    logic            r_out_valid;
    logic [1:0]      r_out_resp;
    logic [META-1:0] r_out_meta;

    logic [QW-1:0]   w_q_data;
    logic [META-1:0] w_q_meta;
    logic [9:0]      w_q_addr;
    logic [9:0]      w_q_len;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_accept;
    logic            w_last;
    logic [10:0]     w_first_inc;
    logic [1:0]      w_err_next;

    dlsc_pcie_s6_respmerge_cmdq #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (QW)
    ) u_cmdq (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (cmd_valid),
        .i_push_data ({cmd_meta, cmd_addr, cmd_len}),
        .i_pop       (w_pop),
        .o_pop_data  (w_q_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign w_q_meta  = w_q_data[QW-1:20];
    assign w_q_addr  = w_q_data[19:10];
    assign w_q_len   = w_q_data[9:0];

    assign cmd_ready = !w_full;
    assign in_ready  = (r_state == ST_ACCUM) && !r_out_valid;
    assign out_valid = r_out_valid;
    assign out_resp  = r_out_resp;
    assign out_meta  = r_out_meta;

    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign w_accept  = in_valid && in_ready;

    // With alignment the first split only runs up to the next max_len boundary.
    assign w_first_inc = (ALIGN != 0)
                       ? (r_max_len - {1'b0, (w_q_addr & len_mask(r_max_len))})
                       : r_max_len;

    // A 1024-DW split covers any command in one go. rem_len==0 encodes 1024 DW,
    // which is never satisfied by a single smaller split.
    assign w_last = (r_max_len == 11'd1024) ||
                    ((r_rem_len != 10'd0) && ({1'b0, r_rem_len} <= r_inc));

    // Sticky first error: once SLVERR/DECERR is held (bit 1 set) it wins.
    assign w_err_next = r_err[1]   ? r_err   :
                        in_resp[1] ? in_resp : RESP_OKAY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_len <= 11'd32;
        end else begin
            r_max_len <= max_len_dw(max_size, MAX_SIZE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rem_len   <= '0;
            r_inc       <= '0;
            r_err       <= RESP_OKAY;
            r_meta      <= '0;
            r_out_valid <= 1'b0;
            r_out_resp  <= RESP_OKAY;
            r_out_meta  <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state   <= ST_ACCUM;
                        r_rem_len <= w_q_len;
                        r_inc     <= w_first_inc;
                        r_meta    <= w_q_meta;
                        r_err     <= RESP_OKAY;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_out_valid <= 1'b1;
                            r_out_resp  <= w_err_next;
                            r_out_meta  <= r_meta;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_rem_len <= r_rem_len - r_inc[9:0];
                            r_inc     <= r_max_len;
                            r_err     <= w_err_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
